// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between N_CH request channels, one transaction in flight at a time.
// kseg0/kseg1 virtual addresses are folded to physical before the request is latched.
module sram_like_arbiter #(
  parameter int N_CH        = 2,
  parameter int DATA_W      = 32,
  parameter int RR_EN       = 1,
  parameter int MAP_EN      = 1,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          ch_req,
  input  logic [N_CH-1:0]          ch_wr,
  input  logic [2*N_CH-1:0]        ch_size,
  input  logic [32*N_CH-1:0]       ch_addr,
  input  logic [DATA_W*N_CH-1:0]   ch_wdata,
  output logic [N_CH-1:0]          ch_addr_ok,
  output logic [N_CH-1:0]          ch_data_ok,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [N_CH-1:0]          ch_err,
  output logic                     m_req,
  output logic                     m_wr,
  output logic [1:0]               m_size,
  output logic [31:0]              m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  input  logic                     m_addr_ok,
  input  logic                     m_data_ok,
  input  logic [DATA_W-1:0]        m_rdata
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    gnt_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;
  logic                m_req_q;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [IDX_W-1:0]    win_d;
  logic [IDX_W-1:0]    ptr_d;
  logic [31:0]         addr_d;
  logic                any_req;

  logic [1:0]          size_arr  [N_CH];
  logic [31:0]         addr_arr  [N_CH];
  logic [DATA_W-1:0]   wdata_arr [N_CH];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign size_arr[gi]  = ch_size[2*gi +: 2];
    assign addr_arr[gi]  = ch_addr[32*gi +: 32];
    assign wdata_arr[gi] = ch_wdata[DATA_W*gi +: DATA_W];
  end

  function automatic logic [31:0] map_addr(input logic [31:0] a);
    if ((MAP_EN != 0) && ((a[31:29] == 3'b100) || (a[31:29] == 3'b101)))
      return {3'b000, a[28:0]};
    return a;
  endfunction

  // Round-robin scans upward from the pointer and wraps; fixed priority keeps the lowest index.
  always_comb begin : p_winner
    int   idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    win_d   = '0;
    any_req = |ch_req;
    if (RR_EN != 0) begin
      for (int k = 0; k < N_CH; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!found && ch_req[IDX_W'(idx)]) begin
          win_d = IDX_W'(idx);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        if (ch_req[IDX_W'(k)]) win_d = IDX_W'(k);
      end
    end
  end

  assign ptr_d  = (win_d == IDX_W'(N_CH - 1)) ? '0 : win_d + 1'b1;
  assign addr_d = map_addr(addr_arr[win_d]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      m_req_q <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            gnt_q   <= win_d;
            ptr_q   <= ptr_d;
            wr_q    <= ch_wr[win_d];
            size_q  <= size_arr[win_d];
            addr_q  <= addr_d;
            wdata_q <= wdata_arr[win_d];
            m_req_q <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (m_addr_ok) begin
            m_req_q <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response in the final timeout cycle still counts as a normal completion.
          if (m_data_ok) begin
            rdata_q <= m_rdata;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_RESP;
          end else if ((TIMEOUT_CYC > 0) && (cnt_q == CNT_LAST)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_RESP;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ch_addr_ok = '0;
    ch_data_ok = '0;
    ch_err     = '0;
    if (!rst && (state_q == S_IDLE) && any_req)
      ch_addr_ok[win_d] = 1'b1;
    if (state_q == S_RESP) begin
      ch_data_ok[gnt_q] = 1'b1;
      ch_err[gnt_q]     = err_q;
    end
  end

  assign ch_rdata = rdata_q;
  assign m_req    = m_req_q;
  assign m_wr     = wr_q;
  assign m_size   = size_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: instance A (round-robin, mapped, 8-cycle timeout) with a hand-driven slave,
// instance B (fixed priority, no mapping) with an always-ready slave.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A
  logic [1:0]  a_req, a_wr, a_addr_ok, a_data_ok, a_err;
  logic [3:0]  a_size;
  logic [63:0] a_addr, a_wdata;
  logic [31:0] a_rdata;
  logic        a_m_req, a_m_wr, a_m_addr_ok, a_m_data_ok;
  logic [1:0]  a_m_size;
  logic [31:0] a_m_addr, a_m_wdata, a_m_rdata;

  // Instance B
  logic [1:0]  b_req, b_wr, b_addr_ok, b_data_ok, b_err;
  logic [3:0]  b_size;
  logic [63:0] b_addr, b_wdata;
  logic [31:0] b_rdata;
  logic        b_m_req, b_m_wr, b_m_addr_ok, b_m_data_ok;
  logic [1:0]  b_m_size;
  logic [31:0] b_m_addr, b_m_wdata;
  logic        b_pend = 1'b0;
  int          b_grants;

  sram_like_arbiter #(.N_CH(2), .DATA_W(32), .RR_EN(1), .MAP_EN(1), .TIMEOUT_CYC(8)) u_a (
    .clk(clk), .rst(rst),
    .ch_req(a_req), .ch_wr(a_wr), .ch_size(a_size), .ch_addr(a_addr), .ch_wdata(a_wdata),
    .ch_addr_ok(a_addr_ok), .ch_data_ok(a_data_ok), .ch_rdata(a_rdata), .ch_err(a_err),
    .m_req(a_m_req), .m_wr(a_m_wr), .m_size(a_m_size), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_addr_ok(a_m_addr_ok), .m_data_ok(a_m_data_ok), .m_rdata(a_m_rdata)
  );

  sram_like_arbiter #(.N_CH(2), .DATA_W(32), .RR_EN(0), .MAP_EN(0), .TIMEOUT_CYC(0)) u_b (
    .clk(clk), .rst(rst),
    .ch_req(b_req), .ch_wr(b_wr), .ch_size(b_size), .ch_addr(b_addr), .ch_wdata(b_wdata),
    .ch_addr_ok(b_addr_ok), .ch_data_ok(b_data_ok), .ch_rdata(b_rdata), .ch_err(b_err),
    .m_req(b_m_req), .m_wr(b_m_wr), .m_size(b_m_size), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_addr_ok(b_m_addr_ok), .m_data_ok(b_m_data_ok), .m_rdata(32'hCAFE_0000)
  );

  // Slave for B: accepts immediately, answers in the first WAIT cycle.
  assign b_m_addr_ok = b_m_req;
  assign b_m_data_ok = b_pend;
  always @(posedge clk) b_pend <= b_m_req & b_m_addr_ok;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One A transaction with an immediate addr_ok and a one-cycle data_ok.
  task automatic a_txn(input logic [1:0] req, input logic [1:0] exp_g, input logic [31:0] exp_addr,
                       input logic exp_wr, input logic [31:0] rdata, input logic keep);
    @(negedge clk);
    a_req = req;
    #1 check("grant", a_addr_ok, exp_g);
    @(negedge clk);
    if (!keep) a_req = 2'b00;
    a_m_addr_ok = 1'b1;
    #1 check("req_m_req", a_m_req, 1'b1);
    check("req_m_addr", a_m_addr, exp_addr);
    check("req_m_wr", a_m_wr, exp_wr);
    check("req_no_grant", a_addr_ok, 2'b00);
    @(negedge clk);
    a_m_addr_ok = 1'b0;
    a_m_data_ok = 1'b1;
    a_m_rdata   = rdata;
    #1 check("wait_m_req", a_m_req, 1'b0);
    @(negedge clk);
    a_m_data_ok = 1'b0;
    #1 check("resp_data_ok", a_data_ok, exp_g);
    check("resp_rdata", a_rdata, rdata);
    check("resp_err", a_err, 2'b00);
    $display("txn grant=%b addr=%h rdata=%h", exp_g, exp_addr, rdata);
  endtask

  initial begin
    rst = 1'b1;
    a_req = 2'b01; a_wr = '0; a_size = 4'b1010; a_addr = '0; a_wdata = '0;
    a_m_addr_ok = 1'b0; a_m_data_ok = 1'b0; a_m_rdata = '0;
    b_req = '0; b_wr = '0; b_size = 4'b1010; b_addr = '0; b_wdata = '0;

    // Reset values, with a request held to confirm no addr_ok leaks during reset
    repeat (2) @(negedge clk);
    #1 check("rst_m_req", a_m_req, 1'b0);
    check("rst_addr_ok", a_addr_ok, 2'b00);
    check("rst_data_ok", a_data_ok, 2'b00);
    check("rst_rdata", a_rdata, 32'h0);
    check("rst_err", a_err, 2'b00);
    check("rst_m_addr", a_m_addr, 32'h0);
    $display("reset state checked");
    @(negedge clk);
    rst = 1'b0;
    a_req = 2'b00;

    // Single kseg1 read on ch0
    a_addr[31:0] = 32'hBFC0_0000;
    a_txn(2'b01, 2'b01, 32'h1FC0_0000, 1'b0, 32'h1234_5678, 1'b0);
    @(negedge clk);
    #1 check("data_ok_one_cycle", a_data_ok, 2'b00);
    check("rdata_hold", a_rdata, 32'h1234_5678);

    // Write on ch1 with addr_ok delayed three cycles
    a_addr[63:32] = 32'h8000_0010; a_wdata[63:32] = 32'hDEAD_BEEF; a_wr = 2'b10; a_size[3:2] = 2'd2;
    @(negedge clk);
    a_req = 2'b10;
    #1 check("wr_grant", a_addr_ok, 2'b10);
    @(negedge clk);
    a_req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      a_m_addr_ok = (i == 3);
      #1 check("wr_m_req", a_m_req, 1'b1);
      check("wr_m_addr", a_m_addr, 32'h0000_0010);
      check("wr_m_wdata", a_m_wdata, 32'hDEAD_BEEF);
      check("wr_m_wr", a_m_wr, 1'b1);
      check("wr_m_size", a_m_size, 2'd2);
    end
    @(negedge clk);
    a_m_addr_ok = 1'b0; a_m_data_ok = 1'b1; a_m_rdata = 32'h0;
    #1 check("wr_wait_m_req", a_m_req, 1'b0);
    @(negedge clk);
    a_m_data_ok = 1'b0;
    #1 check("wr_data_ok", a_data_ok, 2'b10);
    check("wr_err", a_err, 2'b00);
    $display("write ch1 addr=80000010 complete");

    // Round-robin with both channels requesting continuously
    a_wr = 2'b00;
    a_addr = {32'h0000_2000, 32'h0000_1000};
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) a_txn(2'b11, 2'b01, 32'h0000_1000, 1'b0, 32'h100 + i, 1'b1);
      else            a_txn(2'b11, 2'b10, 32'h0000_2000, 1'b0, 32'h100 + i, 1'b1);
    end
    a_req = 2'b00;

    // Addresses outside kseg0/kseg1 pass unchanged
    a_addr = {32'hC000_0000, 32'h0040_0000};
    a_txn(2'b01, 2'b01, 32'h0040_0000, 1'b0, 32'hAAAA_0001, 1'b0);
    a_txn(2'b10, 2'b10, 32'hC000_0000, 1'b0, 32'hAAAA_0002, 1'b0);

    // Timeout on ch0 with ch1 pending, then ch1 answered in the last allowed cycle
    a_addr = {32'h8000_0040, 32'h9000_0000};
    @(negedge clk);
    a_req = 2'b11;
    #1 check("to_grant", a_addr_ok, 2'b01);
    @(negedge clk);
    a_m_addr_ok = 1'b1;
    #1 check("to_m_addr", a_m_addr, 32'h1000_0000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_m_addr_ok = 1'b0;
      #1 check("to_wait_quiet", a_data_ok, 2'b00);
    end
    @(negedge clk);
    #1 check("to_data_ok", a_data_ok, 2'b01);
    check("to_err", a_err, 2'b01);
    check("to_rdata", a_rdata, 32'h0);
    $display("timeout response ch0 err=%b", a_err);
    @(negedge clk);
    #1 check("to_next_grant", a_addr_ok, 2'b10);
    @(negedge clk);
    a_req = 2'b00;
    a_m_addr_ok = 1'b1;
    #1 check("late_m_addr", a_m_addr, 32'h0000_0040);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a_m_addr_ok = 1'b0;
      a_m_data_ok = (i == 7);
      a_m_rdata   = 32'h55AA_55AA;
      #1 check("late_wait_quiet", a_data_ok, 2'b00);
    end
    @(negedge clk);
    a_m_data_ok = 1'b0;
    #1 check("late_data_ok", a_data_ok, 2'b10);
    check("late_err", a_err, 2'b00);
    check("late_rdata", a_rdata, 32'h55AA_55AA);
    $display("last-cycle response ch1 rdata=%h", a_rdata);

    // Reset during WAIT; pointer was 1 after the ch0 grant, must return to 0
    a_addr[31:0] = 32'h0000_0100;
    @(negedge clk);
    a_req = 2'b01;
    #1 check("rst_test_grant", a_addr_ok, 2'b01);
    @(negedge clk);
    a_req = 2'b00;
    a_m_addr_ok = 1'b1;
    @(negedge clk);
    a_m_addr_ok = 1'b0;
    #1 rst = 1'b1;
    a_req = 2'b11;
    a_m_data_ok = 1'b1;
    #1 check("mid_rst_m_req", a_m_req, 1'b0);
    check("mid_rst_addr_ok", a_addr_ok, 2'b00);
    check("mid_rst_data_ok", a_data_ok, 2'b00);
    check("mid_rst_err", a_err, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    a_m_data_ok = 1'b0;
    #1 check("post_rst_grant", a_addr_ok, 2'b01);
    check("post_rst_data_ok", a_data_ok, 2'b00);
    $display("reset during WAIT, first grant=%b", a_addr_ok);
    @(negedge clk);
    a_req = 2'b00;

    // Fixed priority and no mapping on instance B
    b_addr = {32'h0000_0008, 32'hA000_0004};
    b_grants = 0;
    @(negedge clk);
    b_req = 2'b11;
    for (int cyc = 0; cyc < 40 && b_grants < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (b_addr_ok != 2'b00) begin
        check("b_grant", b_addr_ok, 2'b01);
        b_grants++;
        $display("B grant %0d to %b", b_grants, b_addr_ok);
      end
      if (b_m_req) check("b_m_addr", b_m_addr, 32'hA000_0004);
      if (b_data_ok != 2'b00) check("b_rdata", b_rdata, 32'hCAFE_0000);
    end
    check("b_grant_count", b_grants, 4);
    b_req = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Arbitrates N_CH CPU-side sram-like request channels (instruction fetch, data, future cache refill ports) onto one shared sram-like memory port.
- Performs kseg0/kseg1 physical address mapping on the way through.
- Enforces a single outstanding transaction, with fixed-priority or round-robin grant.
- Sits between the CPU core and the memory bridge, replacing direct per-port SRAM wiring.

Parameters:
- N_CH, 2, number of requesting channels (1..8); channel 0 is the lowest index.
- DATA_W, 32, data width; address width is fixed at 32.
- RR_EN, 1, 1 = round-robin grant; 0 = fixed priority with the lowest index winning.
- MAP_EN, 1, 1 = map kseg0/kseg1 addresses to physical; 0 = pass the address through.
- TIMEOUT_CYC, 0, cycles allowed in WAIT before a forced error response; 0 = never time out.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ch_req  in  N_CH  per-channel request
- ch_wr  in  N_CH  per-channel write (1) / read (0)
- ch_size  in  2*N_CH  per-channel size: 0 = byte, 1 = half, 2 = word; channel i uses [2i+1:2i]
- ch_addr  in  32*N_CH  per-channel virtual address; channel i uses [32i+31:32i]
- ch_wdata  in  DATA_W*N_CH  per-channel write data
- ch_addr_ok  out  N_CH  one-hot pulse: request accepted
- ch_data_ok  out  N_CH  one-hot pulse: response returned
- ch_rdata  out  DATA_W  read data, shared by all channels, valid with ch_data_ok
- ch_err  out  N_CH  one-hot pulse with ch_data_ok on timeout
- m_req  out  1  memory-side request
- m_wr  out  1  memory-side write
- m_size  out  2  memory-side size
- m_addr  out  32  memory-side physical address
- m_wdata  out  DATA_W  memory-side write data
- m_addr_ok  in  1  slave accepted the request
- m_data_ok  in  1  slave response / write complete
- m_rdata  in  DATA_W  slave read data

Behaviour:
- Reset values: state = IDLE; all outputs 0; grant register = 0; RR pointer = 0; timeout counter = 0.
- Reset is asynchronous. A reset asserted mid-transaction drops m_req immediately, and no data_ok is issued for the lost transaction.
- State IDLE:
  - g = winner among asserted ch_req. RR_EN=1: first asserted index at or after the RR pointer, wrapping modulo N_CH. RR_EN=0: lowest asserted index.
  - If any request is present: ch_addr_ok[g]=1 combinationally in the same cycle.
  - On the same edge, latch g and the channel's wr, size, mapped addr and wdata; set the RR pointer to (g+1) mod N_CH; go to REQ.
  - The channel treats addr_ok as consumption of its request.
- State REQ:
  - m_req=1, driving the latched fields.
  - On m_addr_ok=1 go to WAIT; otherwise hold all fields stable.
- State WAIT:
  - m_req=0; the counter increments each cycle.
  - On m_data_ok=1: latch m_rdata, go to RESP.
  - If TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC-1 without m_data_ok: latch rdata=0, set the error flag, go to RESP.
  - m_data_ok arriving in the same cycle as the timeout wins: data is latched and there is no error.
  - The counter clears on leaving WAIT.
- State RESP:
  - ch_data_ok[g]=1 for exactly one cycle.
  - ch_rdata = latched data (0 for writes is acceptable; it is ignored by writers).
  - ch_err[g] = error flag.
  - Go to IDLE; clear the error flag.
- ch_rdata holds its value outside RESP. ch_data_ok, ch_addr_ok and ch_err are never asserted for more than one channel at a time.
- Latency: grant at cycle T, m_req at T+1. With immediate addr_ok and a one-cycle data_ok: WAIT at T+2, data_ok seen at T+2, ch_data_ok at T+3. Back-to-back grants are 4 cycles apart minimum.
- No new grant is made while not in IDLE. Requests from other channels stay pending, with no addr_ok.
- Address map (MAP_EN=1):
  - addr[31:29] == 3'b100 (kseg0) or 3'b101 (kseg1) → {3'b000, addr[28:0]}.
  - All other addresses pass unchanged.
  - The mapped address is computed before latching.
- A late m_addr_ok/m_data_ok, or any such input while in IDLE or RESP, is ignored.
- N_CH=1: the arbiter degenerates to a pass-through with the same state sequence.

Test Plan:
- Single read, ch0, addr 0xBFC0_0000; slave answers addr_ok at the first m_req and data_ok the next cycle with 0x1234_5678 → m_addr=0x1FC0_0000, m_wr=0, ch_addr_ok[0] in the grant cycle, ch_data_ok[0] at T+3, ch_rdata=0x1234_5678.
- Write, ch1, addr 0x8000_0010, wdata 0xDEAD_BEEF, size 2; slave delays addr_ok 3 cycles → m_req held 4 cycles with fields stable, then ch_data_ok[1] pulse and ch_err=0.
- RR_EN=1, ch0 and ch1 requesting continuously for 4 transactions → grants alternate 0,1,0,1. With RR_EN=0 the same stimulus → grants 0,0,0,0.
- MAP_EN=1, addr 0x0040_0000 and 0xC000_0000 → passed unchanged. MAP_EN=0, addr 0xA000_0004 → unchanged.
- TIMEOUT_CYC=8, slave never asserts data_ok → ch_data_ok[g] and ch_err[g] pulse 8 cycles after entering WAIT with ch_rdata=0; the next pending request is granted afterwards. data_ok arriving exactly on cycle 8 → no err, data returned.
- Assert rst during WAIT → m_req=0 and all ch_* pulses 0 immediately; after release the first grant goes to ch0 (RR pointer reset).
